// File: rtl/bp_pkg.sv
// Shared definitions for the BTB-based branch predictor: index/tag sizing,
// direction counter encodings and the default-configuration entry layout.
package bp_pkg;

  function automatic int unsigned idx_bits(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned xlen, input int unsigned entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  // Weakly-not-taken / weakly-taken encodings for an arbitrary counter width.
  function automatic int unsigned ctr_wnt_of(input int unsigned bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int unsigned ctr_wt_of(input int unsigned bits);
    return 1 << (bits - 1);
  endfunction

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ENTRIES_DEF  = 16;
  localparam int unsigned CTR_BITS_DEF = 2;
  localparam int unsigned TAG_BITS_DEF = XLEN_DEF - 4 - 2;

  localparam logic [CTR_BITS_DEF-1:0] CTR_WNT = CTR_BITS_DEF'(ctr_wnt_of(CTR_BITS_DEF));
  localparam logic [CTR_BITS_DEF-1:0] CTR_WT  = CTR_BITS_DEF'(ctr_wt_of(CTR_BITS_DEF));

  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]     target;
    logic [CTR_BITS_DEF-1:0] ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one saturating direction counter.
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_cur,
  input  logic                i_inc,
  input  logic                i_dec,
  input  logic                i_set_max,
  input  logic                i_set_init,
  output logic [CTR_BITS-1:0] o_nxt
);

  localparam logic [CTR_BITS-1:0] CtrMax  = '1;
  localparam logic [CTR_BITS-1:0] CtrZero = '0;
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_wt_of(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CtrOne  = CTR_BITS'(1);

  always_comb begin
    o_nxt = i_cur;
    if (i_set_max) begin
      o_nxt = CtrMax;
    end else if (i_set_init) begin
      o_nxt = CtrInit;
    end else if (i_inc && (i_cur != CtrMax)) begin
      o_nxt = i_cur + CtrOne;
    end else if (i_dec && (i_cur != CtrZero)) begin
      o_nxt = i_cur - CtrOne;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters: combinational
// lookup for IF, write-back and misprediction detection for ID.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush_all,
  input  logic [XLEN-1:0]      i_if_pc,
  output logic                 o_pred_hit,
  output logic                 o_pred_taken,
  output logic [XLEN-1:0]      o_pred_target,
  input  logic                 i_upd_valid,
  input  logic [XLEN-1:0]      i_upd_pc,
  input  logic                 i_upd_is_jump,
  input  logic                 i_upd_taken,
  input  logic [XLEN-1:0]      i_upd_target,
  input  logic                 i_upd_pred_taken,
  input  logic [XLEN-1:0]      i_upd_pred_target,
  output logic                 o_mispredict,
  output logic [XLEN-1:0]      o_redirect_pc,
  output logic [STAT_BITS-1:0] o_stat_branches,
  output logic [STAT_BITS-1:0] o_stat_mispredicts
);

  localparam int unsigned IDX_BITS = idx_bits(ENTRIES);
  localparam int unsigned TAG_BITS = tag_bits(XLEN, ENTRIES);

  localparam logic [XLEN-1:0]      PcInc   = XLEN'(4);
  localparam logic [CTR_BITS-1:0]  CtrRst  = CTR_BITS'(ctr_wnt_of(CTR_BITS));
  localparam logic [STAT_BITS-1:0] StatMax = '1;
  localparam logic [STAT_BITS-1:0] StatOne = STAT_BITS'(1);

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t               r_tbl [ENTRIES];
  logic [STAT_BITS-1:0] r_stat_br;
  logic [STAT_BITS-1:0] r_stat_mis;

  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_BITS-1:0] w_if_tag;
  entry_t              w_if_ent;

  assign w_if_idx = i_if_pc[IDX_BITS+1:2];
  assign w_if_tag = i_if_pc[XLEN-1:IDX_BITS+2];
  assign w_if_ent = r_tbl[w_if_idx];

  assign o_pred_hit    = w_if_ent.valid && (w_if_ent.tag == w_if_tag);
  assign o_pred_taken  = o_pred_hit && w_if_ent.ctr[CTR_BITS-1];
  assign o_pred_target = o_pred_taken ? w_if_ent.target : i_if_pc + PcInc;

  logic [IDX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0] w_upd_tag;
  entry_t              w_upd_ent;
  logic                w_upd_hit;
  logic                w_taken;
  logic                w_wr_en;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_nxt;

  assign w_upd_idx = i_upd_pc[IDX_BITS+1:2];
  assign w_upd_tag = i_upd_pc[XLEN-1:IDX_BITS+2];
  assign w_upd_ent = r_tbl[w_upd_idx];
  assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == w_upd_tag);
  // Jumps are always taken regardless of what the core drives on upd_taken.
  assign w_taken   = i_upd_taken || i_upd_is_jump;

  assign o_mispredict  = i_upd_valid &&
                         ((w_taken != i_upd_pred_taken) ||
                          (w_taken && (i_upd_target != i_upd_pred_target)));
  assign o_redirect_pc = w_taken ? i_upd_target : i_upd_pc + PcInc;

  // A not-taken miss leaves the table alone; a flush suppresses any write.
  assign w_wr_en   = i_upd_valid && !i_flush_all && (w_upd_hit || w_taken);
  assign w_ctr_cur = w_upd_hit ? w_upd_ent.ctr : CtrRst;

  bp_sat_ctr #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_ctr (
    .i_cur      (w_ctr_cur),
    .i_inc      (w_upd_hit && w_taken),
    .i_dec      (w_upd_hit && !w_taken),
    .i_set_max  (i_upd_is_jump),
    .i_set_init (!w_upd_hit && !i_upd_is_jump),
    .o_nxt      (w_ctr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_tbl[i].valid  <= 1'b0;
        r_tbl[i].tag    <= '0;
        r_tbl[i].target <= '0;
        r_tbl[i].ctr    <= CtrRst;
      end
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (i_flush_all) begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
          r_tbl[i].valid <= 1'b0;
        end
      end else if (w_wr_en) begin
        r_tbl[w_upd_idx].valid  <= 1'b1;
        r_tbl[w_upd_idx].tag    <= w_upd_tag;
        r_tbl[w_upd_idx].target <= w_taken ? i_upd_target : w_upd_ent.target;
        r_tbl[w_upd_idx].ctr    <= w_ctr_nxt;
      end
      if (i_upd_valid && (r_stat_br != StatMax)) begin
        r_stat_br <= r_stat_br + StatOne;
      end
      if (o_mispredict && (r_stat_mis != StatMax)) begin
        r_stat_mis <= r_stat_mis + StatOne;
      end
    end
  end

  assign o_stat_branches    = r_stat_br;
  assign o_stat_mispredicts = r_stat_mis;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, saturation, aliasing,
// read-before-write, flush and asynchronous reset.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        flush_all;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor #(
    .XLEN      (32),
    .ENTRIES   (16),
    .CTR_BITS  (2),
    .STAT_BITS (32)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_flush_all        (flush_all),
    .i_if_pc            (if_pc),
    .o_pred_hit         (pred_hit),
    .o_pred_taken       (pred_taken),
    .o_pred_target      (pred_target),
    .i_upd_valid        (upd_valid),
    .i_upd_pc           (upd_pc),
    .i_upd_is_jump      (upd_is_jump),
    .i_upd_taken        (upd_taken),
    .i_upd_target       (upd_target),
    .i_upd_pred_taken   (upd_pred_taken),
    .i_upd_pred_target  (upd_pred_target),
    .o_mispredict       (mispredict),
    .o_redirect_pc      (redirect_pc),
    .o_stat_branches    (stat_branches),
    .o_stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one resolved instruction at the falling edge.
  task automatic drive_upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                           input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_jump     = jmp;
    upd_taken       = tkn;
    upd_target      = tgt;
    upd_pred_taken  = ptkn;
    upd_pred_target = ptgt;
    #1;
  endtask

  // Let the edge happen, then idle the update port.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    upd_valid = 1'b0;
    flush_all = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush_all = 1'b0; if_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    #12 rst = 1'b0;
    look(32'h40);
    chk("rst_hit", 32'(pred_hit), 32'd0);
    chk("rst_taken", 32'(pred_taken), 32'd0);
    chk("rst_target", pred_target, 32'h44);
    chk("rst_stat_br", stat_branches, 32'd0);
    chk("rst_stat_mis", stat_mispredicts, 32'd0);
    chk("idle_mispredict", 32'(mispredict), 32'd0);

    // First allocation, with a same-cycle lookup of that index.
    drive_upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    chk("alloc_mispredict", 32'(mispredict), 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h80);
    chk("rbw_hit", 32'(pred_hit), 32'd0);
    tick(); look(32'h40);
    chk("alloc_hit", 32'(pred_hit), 32'd1);
    chk("alloc_taken", 32'(pred_taken), 32'd1);
    chk("alloc_target", pred_target, 32'h80);
    chk("alloc_stat_mis", stat_mispredicts, 32'd1);
    chk("alloc_stat_br", stat_branches, 32'd1);

    // ctr 2 -> 3 -> 3, both correctly predicted.
    drive_upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    chk("correct_pred", 32'(mispredict), 32'd0);
    tick();
    drive_upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    // ctr 3 -> 2: still predicts taken.
    drive_upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    chk("nt_mispredict", 32'(mispredict), 32'd1);
    chk("nt_redirect", redirect_pc, 32'h44);
    tick(); look(32'h40);
    chk("ctr2_taken", 32'(pred_taken), 32'd1);
    // ctr 2 -> 1: weakly not taken.
    drive_upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    tick(); look(32'h40);
    chk("ctr1_hit", 32'(pred_hit), 32'd1);
    chk("ctr1_taken", 32'(pred_taken), 32'd0);
    chk("ctr1_target", pred_target, 32'h44);
    // ctr 1 -> 0 -> 0, then a taken moves it to 1 (still not taken if saturated).
    drive_upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44);
    tick();
    drive_upd(32'h40, 1'b0, 1'b0, 32'h80, 1'b0, 32'h44);
    tick(); look(32'h40);
    chk("ctr0_taken", 32'(pred_taken), 32'd0);
    drive_upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    tick(); look(32'h40);
    chk("sat_floor_taken", 32'(pred_taken), 32'd0);
    chk("stat_br_8", stat_branches, 32'd8);
    chk("stat_mis_4", stat_mispredicts, 32'd4);

    // Aliasing: 0x440 shares index 0 with 0x40.
    look(32'h440);
    chk("alias_miss", 32'(pred_hit), 32'd0);
    drive_upd(32'h440, 1'b1, 1'b1, 32'h100, 1'b0, 32'h444);
    chk("jump_mispredict", 32'(mispredict), 32'd1);
    chk("jump_redirect", redirect_pc, 32'h100);
    tick(); look(32'h40);
    chk("evicted_miss", 32'(pred_hit), 32'd0);
    look(32'h440);
    chk("jump_hit", 32'(pred_hit), 32'd1);
    chk("jump_taken", 32'(pred_taken), 32'd1);
    chk("jump_target", pred_target, 32'h100);

    // Correct jump prediction, then a wrong predicted target.
    drive_upd(32'h440, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100);
    chk("jump_correct", 32'(mispredict), 32'd0);
    tick();
    drive_upd(32'h440, 1'b1, 1'b1, 32'h100, 1'b1, 32'h104);
    chk("target_mismatch", 32'(mispredict), 32'd1);
    tick();
    // Not-taken miss leaves the table untouched.
    drive_upd(32'h80, 1'b0, 1'b0, 32'h200, 1'b0, 32'h84);
    chk("ntmiss_mispredict", 32'(mispredict), 32'd0);
    chk("ntmiss_redirect", redirect_pc, 32'h84);
    tick(); look(32'h80);
    chk("ntmiss_no_alloc", 32'(pred_hit), 32'd0);

    // Second entry, then flush together with an allocation attempt.
    drive_upd(32'h84, 1'b1, 1'b1, 32'h200, 1'b0, 32'h88);
    tick(); look(32'h84);
    chk("idx1_hit", 32'(pred_hit), 32'd1);
    drive_upd(32'h88, 1'b1, 1'b1, 32'h300, 1'b0, 32'h8c);
    flush_all = 1'b1;
    tick();
    look(32'h440);
    chk("flush_miss_440", 32'(pred_hit), 32'd0);
    look(32'h84);
    chk("flush_miss_84", 32'(pred_hit), 32'd0);
    look(32'h88);
    chk("flush_no_alloc", 32'(pred_hit), 32'd0);
    chk("flush_stat_br", stat_branches, 32'd14);
    chk("flush_stat_mis", stat_mispredicts, 32'd8);

    // Reallocate, then reset asynchronously mid-cycle with an update pending.
    drive_upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0, 32'h44);
    tick(); look(32'h40);
    chk("realloc_hit", 32'(pred_hit), 32'd1);
    drive_upd(32'h80, 1'b1, 1'b1, 32'h400, 1'b0, 32'h84);
    #2 rst = 1'b1;
    #1;
    chk("arst_stat_br", stat_branches, 32'd0);
    chk("arst_stat_mis", stat_mispredicts, 32'd0);
    chk("arst_hit", 32'(pred_hit), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b0;
    look(32'h80);
    chk("arst_upd_lost", 32'(pred_hit), 32'd0);
    chk("arst_target", pred_target, 32'h84);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
